// File: rtl/reduce_pkg.sv
// Shared types for the reduce_accum streaming reduction block.
//   mode_e  : per-beat vs. frame-accumulate selection carried on in_mode
//   state_e : frame FSM state encoding
package reduce_pkg;

    typedef enum logic {
        MODE_BEAT  = 1'b0,
        MODE_FRAME = 1'b1
    } mode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_e;

endpackage : reduce_pkg

// File: rtl/reduce_accum_popcount.sv
// Purely combinational population count of a WIDTH-bit vector.
//   data_i  : WIDTH-bit input vector
//   count_o : number of 1 bits in data_i, $clog2(WIDTH+1) bits
module popcount #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0]             data_i,
    output logic [$clog2(WIDTH+1)-1:0]   count_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Ripple sum of single bits; synthesis rebalances into an adder tree.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            count_o = count_o + CNT_W'(data_i[i]);
        end
    end

endmodule : popcount

// File: rtl/reduce_accum.sv
// Streaming AND/OR/XOR/popcount reduction, per beat or accumulated over a
// frame of up to FRAME_LEN beats, with a registered valid/ready result.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input beat handshake
//   in_data             : WIDTH bits reduced per beat
//   in_mode             : 0 per-beat, 1 frame (sampled on first beat only)
//   in_last             : closes a frame early
//   out_valid/out_ready : result handshake
//   out_and/or/xor      : reductions over all contributing bits
//   out_count           : number of 1 bits contributing
//   out_beats           : number of beats contributing
module reduce_accum
    import reduce_pkg::*;
#(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned FRAME_LEN = 4,
    localparam int unsigned CW       = $clog2(WIDTH * FRAME_LEN + 1),
    localparam int unsigned BW       = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_and,
    output logic             out_or,
    output logic             out_xor,
    output logic [CW-1:0]    out_count,
    output logic [BW-1:0]    out_beats
);

    localparam int unsigned PW = $clog2(WIDTH + 1);

    state_e         state_q,   state_d;
    logic           acc_and_q, acc_and_d;
    logic           acc_or_q,  acc_or_d;
    logic           acc_xor_q, acc_xor_d;
    logic [CW-1:0]  acc_pop_q, acc_pop_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;

    logic           res_valid_q, res_valid_d;
    logic           res_and_q,   res_and_d;
    logic           res_or_q,    res_or_d;
    logic           res_xor_q,   res_xor_d;
    logic [CW-1:0]  res_count_q, res_count_d;
    logic [BW-1:0]  res_beats_q, res_beats_d;

    logic           accept;
    logic           beat_and, beat_or, beat_xor;
    logic [PW-1:0]  beat_pop;
    logic [CW-1:0]  beat_pop_ext;
    logic           nxt_and, nxt_or, nxt_xor;
    logic [CW-1:0]  nxt_pop;
    logic [BW-1:0]  nxt_cnt;

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .data_i  (in_data),
        .count_o (beat_pop)
    );

    // Ready only when the result slot is free or draining this cycle.
    assign in_ready = !rst && (!res_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Per-beat reductions.
    assign beat_and     = &in_data;
    assign beat_or      = |in_data;
    assign beat_xor     = ^in_data;
    assign beat_pop_ext = CW'(beat_pop);

    // Accumulators combined with the current beat (used in S_ACCUM).
    assign nxt_and = acc_and_q & beat_and;
    assign nxt_or  = acc_or_q  | beat_or;
    assign nxt_xor = acc_xor_q ^ beat_xor;
    assign nxt_pop = acc_pop_q + beat_pop_ext;
    assign nxt_cnt = beat_cnt_q + BW'(1);

    // Next-state and result-register load logic.
    always_comb begin
        state_d     = state_q;
        acc_and_d   = acc_and_q;
        acc_or_d    = acc_or_q;
        acc_xor_d   = acc_xor_q;
        acc_pop_d   = acc_pop_q;
        beat_cnt_d  = beat_cnt_q;
        res_valid_d = res_valid_q && !out_ready;
        res_and_d   = res_and_q;
        res_or_d    = res_or_q;
        res_xor_d   = res_xor_q;
        res_count_d = res_count_q;
        res_beats_d = res_beats_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (mode_e'(in_mode) == MODE_BEAT) begin
                        res_valid_d = 1'b1;
                        res_and_d   = beat_and;
                        res_or_d    = beat_or;
                        res_xor_d   = beat_xor;
                        res_count_d = beat_pop_ext;
                        res_beats_d = BW'(1);
                    end else begin
                        acc_and_d  = beat_and;
                        acc_or_d   = beat_or;
                        acc_xor_d  = beat_xor;
                        acc_pop_d  = beat_pop_ext;
                        beat_cnt_d = BW'(1);
                        if (in_last || (FRAME_LEN == 1)) begin
                            res_valid_d = 1'b1;
                            res_and_d   = beat_and;
                            res_or_d    = beat_or;
                            res_xor_d   = beat_xor;
                            res_count_d = beat_pop_ext;
                            res_beats_d = BW'(1);
                        end else begin
                            state_d = S_ACCUM;
                        end
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_and_d  = nxt_and;
                    acc_or_d   = nxt_or;
                    acc_xor_d  = nxt_xor;
                    acc_pop_d  = nxt_pop;
                    beat_cnt_d = nxt_cnt;
                    if (in_last || (nxt_cnt == BW'(FRAME_LEN))) begin
                        res_valid_d = 1'b1;
                        res_and_d   = nxt_and;
                        res_or_d    = nxt_or;
                        res_xor_d   = nxt_xor;
                        res_count_d = nxt_pop;
                        res_beats_d = nxt_cnt;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_and_q   <= 1'b0;
            acc_or_q    <= 1'b0;
            acc_xor_q   <= 1'b0;
            acc_pop_q   <= '0;
            beat_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_and_q   <= 1'b0;
            res_or_q    <= 1'b0;
            res_xor_q   <= 1'b0;
            res_count_q <= '0;
            res_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_and_q   <= acc_and_d;
            acc_or_q    <= acc_or_d;
            acc_xor_q   <= acc_xor_d;
            acc_pop_q   <= acc_pop_d;
            beat_cnt_q  <= beat_cnt_d;
            res_valid_q <= res_valid_d;
            res_and_q   <= res_and_d;
            res_or_q    <= res_or_d;
            res_xor_q   <= res_xor_d;
            res_count_q <= res_count_d;
            res_beats_q <= res_beats_d;
        end
    end

    assign out_valid = res_valid_q;
    assign out_and   = res_and_q;
    assign out_or    = res_or_q;
    assign out_xor   = res_xor_q;
    assign out_count = res_count_q;
    assign out_beats = res_beats_q;

endmodule : reduce_accum

// File: tb/tb_reduce_accum.sv
// Directed self-checking bench for reduce_accum (WIDTH=3, FRAME_LEN=4).
module tb_reduce_accum;

    localparam int unsigned WIDTH     = 3;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned CW        = $clog2(WIDTH * FRAME_LEN + 1);
    localparam int unsigned BW        = $clog2(FRAME_LEN + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_and;
    logic             out_or;
    logic             out_xor;
    logic [CW-1:0]    out_count;
    logic [BW-1:0]    out_beats;

    int vectors;
    int miscompares;

    reduce_accum #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_and   (out_and),
        .out_or    (out_or),
        .out_xor   (out_xor),
        .out_count (out_count),
        .out_beats (out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic a, input logic o,
                             input logic x, input int c, input int b);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".and"},   32'(out_and),   32'(a));
        check({tag, ".or"},    32'(out_or),    32'(o));
        check({tag, ".xor"},   32'(out_xor),   32'(x));
        check({tag, ".count"}, 32'(out_count), 32'(c));
        check({tag, ".beats"}, 32'(out_beats), 32'(b));
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic m, input logic l);
        in_valid = v;
        in_data  = d;
        in_mode  = m;
        in_last  = l;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        out_ready   = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 1'b0);

        // Reset
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // Per-beat 111
        drive(1'b1, 3'b111, 1'b0, 1'b0);
        step();
        check_out("beat111", 1'b1, 1'b1, 1'b1, 1'b1, 3, 1);

        // Per-beat back-to-back 000 then 101
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        step();
        check_out("beat000", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
        drive(1'b1, 3'b101, 1'b0, 1'b0);
        step();
        check_out("beat101", 1'b1, 1'b0, 1'b1, 1'b0, 2, 1);
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("beat_drain", 32'(out_valid), 32'd0);

        // Full frame 111,011,111,110 with in_mode low on beats 2-4
        drive(1'b1, 3'b111, 1'b1, 1'b0);
        step();
        check("frm_b1", 32'(out_valid), 32'd0);
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        step();
        check("frm_b2", 32'(out_valid), 32'd0);
        drive(1'b1, 3'b111, 1'b0, 1'b0);
        step();
        check("frm_b3", 32'(out_valid), 32'd0);
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        step();
        check_out("frm4", 1'b1, 1'b0, 1'b1, 1'b0, 10, 4);
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("frm_drain", 32'(out_valid), 32'd0);

        // Early close 100, 001+last, then a new 2-beat frame 111, 010+last
        drive(1'b1, 3'b100, 1'b1, 1'b0);
        step();
        check("early_b1", 32'(out_valid), 32'd0);
        drive(1'b1, 3'b001, 1'b0, 1'b1);
        step();
        check_out("early", 1'b1, 1'b0, 1'b1, 1'b0, 2, 2);
        drive(1'b1, 3'b111, 1'b1, 1'b0);
        step();
        check("next_b1", 32'(out_valid), 32'd0);
        drive(1'b1, 3'b010, 1'b0, 1'b1);
        step();
        check_out("next", 1'b1, 1'b0, 1'b1, 1'b0, 4, 2);

        // Backpressure: hold a pending 011 result for 5 cycles
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        step();
        check_out("bp_load", 1'b1, 1'b0, 1'b1, 1'b0, 2, 1);
        out_ready = 1'b0;
        drive(1'b1, 3'b111, 1'b0, 1'b0);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check_out("bp_hold", 1'b1, 1'b0, 1'b1, 1'b0, 2, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        check_out("bp_next", 1'b1, 1'b1, 1'b1, 1'b1, 3, 1);
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("bp_drain", 32'(out_valid), 32'd0);

        // Reset after two frame beats discards the partial frame
        drive(1'b1, 3'b111, 1'b1, 1'b0);
        step();
        drive(1'b1, 3'b111, 1'b0, 1'b0);
        step();
        check("mid_b2", 32'(out_valid), 32'd0);
        rst = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        check_out("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;

        // Fresh frame 101,010,001,100
        drive(1'b1, 3'b101, 1'b1, 1'b0);
        step();
        drive(1'b1, 3'b010, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        step();
        check("fresh_b3", 32'(out_valid), 32'd0);
        drive(1'b1, 3'b100, 1'b0, 1'b0);
        step();
        check_out("fresh", 1'b1, 1'b0, 1'b1, 1'b1, 5, 4);
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("fresh_drain", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_reduce_accum
